alu_issue_stage: RTL
====================

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 The block SHALL have the port `clk`: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port `reset`: input, 1 bit, synchronous, active-high.
REQ-003 The block SHALL have the port `flush`: input, 1 bit, synchronous discard of all buffered entries (branch redirect).
REQ-004 The block SHALL have the port `in_valid`: input, 1 bit, upstream offers an instruction.
REQ-005 The block SHALL have the port `in_ready`: output, 1 bit, registered; block accepts when high.
REQ-006 The block SHALL have the port `instr`: input, 32 bits, RV instruction word.
REQ-007 The block SHALL have the ports `rs1_data` and `rs2_data`: input, 64 bits each, register-file read data for instr.
REQ-008 The block SHALL have the port `fwd_valid`: input, 1 bit, EX result write-back is valid this cycle.
REQ-009 The block SHALL have the port `fwd_rd`: input, 5 bits, destination of the EX result.
REQ-010 The block SHALL have the port `fwd_data`: input, 64 bits, EX result value.
REQ-011 The block SHALL have the port `out_valid`: output, 1 bit, head entry presented to the ALU.
REQ-012 The block SHALL have the port `out_ready`: input, 1 bit, ALU/EX consumes the head entry.
REQ-013 The block SHALL have the ports `op0` and `op1`: output, 64 bits each, ALU operands.
REQ-014 The block SHALL have the ports `func3` (output, 3 bits), `func7` (output, 7 bits) and `ctrl` (output, 6 bits), the ALU control fields.
REQ-015 The block SHALL have the port `rd`: output, 5 bits, destination register of the head entry.
REQ-016 The block SHALL have the port `illegal`: output, 1 bit, head opcode is not supported.

Function
REQ-017 The block SHALL be a 2-entry skid buffer with states EMPTY, ONE and TWO.
REQ-018 The block SHALL transfer in on `in_valid` & `in_ready` and out on `out_valid` & `out_ready` at the same clock edge.
REQ-019 The block SHALL make state transitions as follows: EMPTY->ONE on in; ONE->TWO on in without out; ONE->EMPTY on out without in; ONE stays on in and out; TWO->ONE on out.
REQ-020 The block SHALL never accept in TWO.
REQ-021 The block SHALL drive `in_ready` = (next state != TWO), registered; `out_valid` = (state != EMPTY).
REQ-022 The block SHALL maintain FIFO order; outputs SHALL come from the head entry and SHALL be held stable while `out_valid` & !`out_ready`.
REQ-023 The block SHALL have a latency of 1 cycle: an instruction accepted at edge N SHALL be presented at edge N+1 when the buffer was EMPTY.
REQ-024 The block SHALL apply capture-time operand forwarding: if `fwd_valid` & `fwd_rd` == `instr[19:15]` & `fwd_rd` != 0, the rs1 value SHALL be `fwd_data`, else `rs1_data`; rs2 SHALL be handled likewise with `instr[24:20]`.
REQ-025 The block SHALL force any source register index 0 to read 64'h0, regardless of `rs*_data` or forwarding.
REQ-026 The block SHALL decode R-type opcode 0110011 as: `op0`=rs1, `op1`=rs2, `func7`=`instr[31:25]`.
REQ-027 The block SHALL decode I-type ALU opcode 0010011 as: `op0`=rs1, `op1`=sign-extended `instr[31:20]` to 64 bits, `func7`=0 except func3=001 (SLLI), where `op1`=zero-extended `instr[24:20]`.
REQ-028 The block SHALL decode branch opcode 1100011 as: `op0`=rs1, `op1`=rs2, `func7`=0, `rd`=0.
REQ-029 The block SHALL drive `func3`=`instr[14:12]` for all opcodes.
REQ-030 The block SHALL drive `ctrl`={`instr[6:2]`, is_imm}, where is_imm=1 only for I-type.
REQ-031 The block SHALL treat any other opcode as unsupported: captured with `illegal`=1, `op0`=`op1`=0, `func7`=0, `ctrl`=0, `rd`=0.
REQ-032 The block SHALL give `flush` priority over in and out that cycle: state->EMPTY, no capture, `out_valid`=0 and `in_ready`=1 the next cycle.
REQ-033 The block SHALL give forwarded data no effect on entries already buffered; operands SHALL be frozen at capture.

Reset
REQ-034 The block SHALL, on `reset` high at a clock edge, set state=EMPTY, `out_valid`=0 and `in_ready`=1, and zero `op0`, `op1`, `func3`, `func7`, `ctrl`, `rd` and `illegal`.
REQ-035 The block SHALL give `reset` priority over `flush` and all handshakes; a reset mid-operation SHALL discard both entries.

Verification
REQ-036 The bench SHALL cover: ADDI x5,x1,-1 with rs1_data=10 into EMPTY -> next cycle `out_valid`=1, `op0`=10, `op1`=64'hFFFF_FFFF_FFFF_FFFF, `ctrl`=6'b001001, `rd`=5.
REQ-037 The bench SHALL cover: SUB x3,x1,x2 with fwd_valid=1, fwd_rd=2, fwd_data=7, rs2_data=99 -> `op1`=7, `func7`=0100000.
REQ-038 The bench SHALL cover: ADD x4,x0,x2 with rs1_data=55 -> `op0`=0; fwd_rd=0 with fwd_valid=1 -> no substitution.
REQ-039 The bench SHALL cover: out_ready=0 with three back-to-back offers -> two accepted, `in_ready`=0, third held; out_ready=1 -> entries emerge in order, third then accepted.
REQ-040 The bench SHALL cover: state TWO with flush=1 and in_valid=1 -> next cycle `out_valid`=0, `in_ready`=1, no entry captured.
REQ-041 The bench SHALL cover: opcode 0000011 (load) -> `illegal`=1, `ctrl`=0; reset asserted in ONE -> `out_valid`=0 and all outputs 0 next cycle.

Source files
------------

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: 2-entry skid buffer between decode and the ALU.
// Operands are resolved (x0, forwarding, immediates) at capture time and frozen.
`default_nettype none

module alu_issue_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [63:0] rs1_data,
  input  logic [63:0] rs2_data,
  input  logic        fwd_valid,
  input  logic [4:0]  fwd_rd,
  input  logic [63:0] fwd_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] op0,
  output logic [63:0] op1,
  output logic [2:0]  func3,
  output logic [6:0]  func7,
  output logic [5:0]  ctrl,
  output logic [4:0]  rd,
  output logic        illegal
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_BR  = 7'b1100011;

  typedef struct packed {
    logic        ill;
    logic [4:0]  rd;
    logic [5:0]  ctrl;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [63:0] op1;
    logic [63:0] op0;
  } entry_t;

  logic [1:0] state_q, state_d;
  entry_t     head_q, head_d;
  entry_t     tail_q, tail_d;
  logic       in_ready_q;

  entry_t      cap;
  logic [63:0] src1, src2;
  logic        do_in, do_out;

  // Source index 0 always reads zero, so the fwd_rd != 0 guard is implied.
  always_comb begin
    if (instr[19:15] == 5'd0)
      src1 = 64'h0;
    else if (fwd_valid && (fwd_rd == instr[19:15]))
      src1 = fwd_data;
    else
      src1 = rs1_data;

    if (instr[24:20] == 5'd0)
      src2 = 64'h0;
    else if (fwd_valid && (fwd_rd == instr[24:20]))
      src2 = fwd_data;
    else
      src2 = rs2_data;
  end

  always_comb begin
    cap     = '0;
    cap.f3  = instr[14:12];
    case (instr[6:0])
      OPC_R: begin
        cap.op0  = src1;
        cap.op1  = src2;
        cap.f7   = instr[31:25];
        cap.rd   = instr[11:7];
        cap.ctrl = {instr[6:2], 1'b0};
      end
      OPC_I: begin
        cap.op0  = src1;
        cap.op1  = (instr[14:12] == 3'b001) ? {59'h0, instr[24:20]}
                                             : {{52{instr[31]}}, instr[31:20]};
        cap.rd   = instr[11:7];
        cap.ctrl = {instr[6:2], 1'b1};
      end
      OPC_BR: begin
        cap.op0  = src1;
        cap.op1  = src2;
        cap.ctrl = {instr[6:2], 1'b0};
      end
      default: cap.ill = 1'b1;
    endcase
  end

  assign do_in  = in_valid & in_ready_q;
  assign do_out = (state_q != S_EMPTY) & out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      S_EMPTY: begin
        if (do_in) begin
          head_d  = cap;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        if (do_in && do_out) begin
          head_d = cap;
        end else if (do_in) begin
          tail_d  = cap;
          state_d = S_TWO;
        end else if (do_out) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        // in_ready is low here, so only a pop can happen.
        if (do_out) begin
          head_d  = tail_q;
          state_d = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_EMPTY;
      in_ready_q <= 1'b1;
      head_q     <= '0;
      tail_q     <= '0;
    end else if (flush) begin
      state_q    <= S_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != S_TWO);
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != S_EMPTY);
  assign op0       = head_q.op0;
  assign op1       = head_q.op1;
  assign func3     = head_q.f3;
  assign func7     = head_q.f7;
  assign ctrl      = head_q.ctrl;
  assign rd        = head_q.rd;
  assign illegal   = head_q.ill;

endmodule

`default_nettype wire
